// File: rtl/chip8_alu_sequencer.sv
// Sequences one Chip-8 8XYN ALU instruction: read Vx/Vy, run the ALU,
// write Vx then VF. Ports: clk/reset, start/opcode, reg file, ALU, status.
module chip8_alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic [3:0]  reg_addr,
  input  logic [7:0]  reg_rdata,
  output logic        reg_we,
  output logic [7:0]  reg_wdata,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [3:0]  alu_sel,
  input  logic [15:0] alu_out,
  input  logic        alu_carry,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    IDLE, RD_X, RD_Y, LAT, EXEC, CMP, WB_X, WB_F, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] x_q, y_q, n_q;
  logic [7:0] vx_q, vy_q, res_q;
  logic       flag_q, ill_q;

  logic       legal;
  logic [7:0] exec_res;
  logic       exec_flag;
  logic       cmp_flag;
  logic       unused_ok;

  // Only the low byte of the ALU result is ever written back.
  assign unused_ok = ^alu_out[15:8];

  assign legal = (opcode[15:12] == 4'h8) &&
                 (!opcode[3] || (opcode[3:0] == 4'hE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      vx_q   <= '0;
      vy_q   <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            ill_q <= !legal;
            if (legal) begin
              x_q <= opcode[11:8];
              y_q <= opcode[7:4];
              n_q <= opcode[3:0];
            end
          end
        end
        RD_Y: vx_q <= reg_rdata;
        LAT:  vy_q <= reg_rdata;
        EXEC: begin
          res_q  <= exec_res;
          flag_q <= exec_flag;
        end
        CMP:  flag_q <= cmp_flag;
        DONE: ill_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    reg_addr  = '0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    alu_in1   = '0;
    alu_in2   = '0;
    alu_sel   = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    exec_res  = '0;
    exec_flag = 1'b0;
    cmp_flag  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = legal ? RD_X : DONE;
      end
      RD_X: begin
        reg_addr  = x_q;
        state_nxt = RD_Y;
      end
      RD_Y: begin
        reg_addr  = y_q;
        state_nxt = LAT;
      end
      LAT: state_nxt = EXEC;
      EXEC: begin
        alu_in1  = {8'h00, vx_q};
        alu_in2  = {8'h00, vy_q};
        exec_res = alu_out[7:0];
        case (n_q)
          4'h0: begin
            alu_sel  = 4'd0;
            exec_res = vy_q;
          end
          4'h1: alu_sel = 4'd1;
          4'h2: alu_sel = 4'd2;
          4'h3: alu_sel = 4'd3;
          4'h4: begin
            alu_sel   = 4'd4;
            exec_flag = alu_carry;
          end
          4'h5: alu_sel = 4'd5;
          4'h7: begin
            alu_sel = 4'd5;
            alu_in1 = {8'h00, vy_q};
            alu_in2 = {8'h00, vx_q};
          end
          4'h6: begin
            alu_sel   = 4'd7;
            alu_in2   = 16'd1;
            exec_flag = vx_q[0];
          end
          4'hE: begin
            alu_sel   = 4'd6;
            alu_in2   = 16'd1;
            exec_flag = vx_q[7];
          end
          default: ;
        endcase
        state_nxt = (n_q == 4'h5 || n_q == 4'h7) ? CMP : WB_X;
      end
      CMP: begin
        // ALU compare returns in1 > in2; no-borrow is its inverse.
        alu_sel = 4'd9;
        if (n_q == 4'h5) begin
          alu_in1 = {8'h00, vy_q};
          alu_in2 = {8'h00, vx_q};
        end else begin
          alu_in1 = {8'h00, vx_q};
          alu_in2 = {8'h00, vy_q};
        end
        cmp_flag  = ~alu_out[0];
        state_nxt = WB_X;
      end
      WB_X: begin
        reg_we    = 1'b1;
        reg_addr  = x_q;
        reg_wdata = res_q;
        state_nxt = (n_q >= 4'h4) ? WB_F : DONE;
      end
      WB_F: begin
        // Written last so VF ends with the flag even when X is F.
        reg_we    = 1'b1;
        reg_addr  = 4'hF;
        reg_wdata = {7'b0, flag_q};
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        illegal   = ill_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Scoreboard bench for chip8_alu_sequencer with a register-file and
// ALU model; directed 8XYN vectors with hand-computed results.
module tb_chip8_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] opcode = '0;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_rdata = '0;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [15:0] alu_in1, alu_in2;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_carry;
  logic        busy, done, illegal;

  chip8_alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata), .reg_we(reg_we),
    .reg_wdata(reg_wdata), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [7:0] regs [16];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    reg_rdata <= regs[reg_addr];
    if (reg_we) regs[reg_addr] = reg_wdata;
  end

  logic [8:0] sum9;
  always_comb begin
    sum9      = {1'b0, alu_in1[7:0]} + {1'b0, alu_in2[7:0]};
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_sel)
      4'd0: alu_out = alu_in2;
      4'd1: alu_out = alu_in1 | alu_in2;
      4'd2: alu_out = alu_in1 & alu_in2;
      4'd3: alu_out = alu_in1 ^ alu_in2;
      4'd4: begin
        alu_out   = {7'b0, sum9};
        alu_carry = sum9[8];
      end
      4'd5: alu_out = alu_in1 - alu_in2;
      4'd6: alu_out = alu_in1 << alu_in2;
      4'd7: alu_out = alu_in1 >> alu_in2;
      4'd9: alu_out = {15'b0, (alu_in1 > alu_in2)};
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    string      name;
    logic       ill;
    int         lat;
    int         wr;
    logic [3:0] x;
    logic [7:0] vx;
    logic [7:0] vf;
    int         t0;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (reg_we) wr_cnt++;
    if (!reset) begin
      checks++;
      if ((!busy && (reg_we || reg_wdata != 0 || alu_sel != 0 ||
           alu_in1 != 0 || alu_in2 != 0)) || (illegal && !done)) begin
        errors++;
        $display("FAIL idle_outputs t=%0t we=%b sel=%0d ill=%b done=%b",
                 $time, reg_we, alu_sel, illegal, done);
      end
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done t=%0t", $time);
      end else begin
        e = sb.pop_front();
        checks++;
        if (illegal !== e.ill) begin
          errors++;
          $display("FAIL %s illegal got %b want %b", e.name, illegal, e.ill);
        end
        checks++;
        if (cyc - e.t0 != e.lat) begin
          errors++;
          $display("FAIL %s latency got %0d want %0d",
                   e.name, cyc - e.t0, e.lat);
        end
        checks++;
        if (wr_cnt != e.wr) begin
          errors++;
          $display("FAIL %s writes got %0d want %0d", e.name, wr_cnt, e.wr);
        end
        if (!e.ill) begin
          checks++;
          if (regs[e.x] !== e.vx) begin
            errors++;
            $display("FAIL %s vx got %h want %h", e.name, regs[e.x], e.vx);
          end
          checks++;
          if (regs[15] !== e.vf) begin
            errors++;
            $display("FAIL %s vf got %h want %h", e.name, regs[15], e.vf);
          end
        end
      end
      wr_cnt = 0;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done, %0d pending", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [15:0] op,
                     input logic ill, input int lat, input int wr,
                     input logic [7:0] vx, input logic [7:0] vf,
                     input bit poke);
    exp_t e;
    e.name = name; e.ill = ill; e.lat = lat; e.wr = wr;
    e.x = op[11:8]; e.vx = vx; e.vf = vf; e.t0 = cyc;
    sb.push_back(e);
    start  = 1'b1;
    opcode = op;
    @(posedge clk);
    #1;
    start  = poke;
    opcode = 16'h8120;
    if (poke) begin
      @(posedge clk);
      #1;
      opcode = 16'h8000;
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    opcode = 16'($urandom);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_sel", alu_sel, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    regs[1] = 8'hF0; regs[2] = 8'h20; regs[15] = 8'h00;
    run("add_ovf", 16'h8124, 0, 7, 2, 8'h10, 8'h01, 1);
    regs[3] = 8'h05; regs[4] = 8'h07;
    run("sub_borrow", 16'h8345, 0, 8, 2, 8'hFE, 8'h00, 0);
    regs[3] = 8'h07; regs[4] = 8'h07;
    run("sub_equal", 16'h8345, 0, 8, 2, 8'h00, 8'h01, 0);
    regs[15] = 8'h81;
    run("shl_vf", 16'h8FFE, 0, 7, 2, 8'h01, 8'h01, 0);
    regs[15] = 8'hAA;
    run("ill_n8", 16'h8128, 1, 1, 0, 8'h00, 8'h00, 0);
    run("ill_op", 16'h1234, 1, 1, 0, 8'h00, 8'h00, 0);
    regs[5] = 8'h0C; regs[6] = 8'h30;
    run("or", 16'h8561, 0, 6, 1, 8'h3C, 8'hAA, 0);
    regs[5] = 8'h3C; regs[6] = 8'h0F;
    run("and", 16'h8562, 0, 6, 1, 8'h0C, 8'hAA, 0);
    regs[5] = 8'hFF; regs[6] = 8'h0F;
    run("xor", 16'h8563, 0, 6, 1, 8'hF0, 8'hAA, 0);
    regs[6] = 8'h5A;
    run("ld", 16'h8560, 0, 6, 1, 8'h5A, 8'hAA, 0);
    regs[7] = 8'h03;
    run("shr", 16'h8786, 0, 7, 2, 8'h01, 8'h01, 0);
    regs[10] = 8'h10; regs[9] = 8'h30;
    run("subn_ok", 16'h8A97, 0, 8, 2, 8'h20, 8'h01, 0);
    regs[10] = 8'h30; regs[9] = 8'h10;
    run("subn_borrow", 16'h8A97, 0, 8, 2, 8'hE0, 8'h00, 0);

    regs[1] = 8'hF0; regs[2] = 8'h20; regs[15] = 8'h77;
    start  = 1'b1;
    opcode = 16'h8124;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("exec_sel", alu_sel, 4);
    chk("exec_in1", alu_in1, 16'h00F0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_wr", wr_cnt, 0);
    chk("abort_v1", regs[1], 8'hF0);
    chk("abort_vf", regs[15], 8'h77);
    chk("abort_sb", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
